imem_responder: RTL and testbench

- Memory-side responder for the instruction-prefetch bus: the far end of the interface the prefetcher drives.
- Accepts BUS_LOAD/BUS_STORE commands, acknowledges each accepted command with a 4-bit response tag in the same cycle, and returns load data tagged after a fixed latency.
- Sits between the prefetch/icache request port and a behavioural line-addressed memory array.
- Used as the memory model in system simulation and unit benches.

---
 rtl/sys_defs.sv | 12 +
 rtl/mem_tag_alloc.sv | 38 +++
 rtl/imem_responder.sv | 108 ++++++++++
 tb/tb_imem_responder.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/sys_defs.sv
// Shared bus definitions for the instruction-prefetch memory interface.
package sys_defs;
  localparam int SYS_XLEN = 32;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } BUS_COMMAND;

  typedef logic [3:0] MEM_TAG;
endpackage

// File: rtl/mem_tag_alloc.sv
// Response tag pool: busy vector, lowest-free encoder, allocate/release update.
module mem_tag_alloc
  import sys_defs::*;
#(
  parameter int MAX_OUTSTANDING = 15
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   i_alloc,
  input  logic   i_release,
  input  MEM_TAG i_rel_tag,
  output MEM_TAG o_free_tag,
  output logic   o_full
);
  logic [MAX_OUTSTANDING:1] r_busy;
  MEM_TAG                   w_free_tag;

  // Descending scan so the lowest free tag is the last one written.
  always_comb begin
    w_free_tag = '0;
    for (int i = MAX_OUTSTANDING; i >= 1; i--)
      if (!r_busy[i]) w_free_tag = MEM_TAG'(i);
  end

  assign o_free_tag = w_free_tag;
  assign o_full     = &r_busy;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_busy <= '0;
    end else begin
      for (int i = 1; i <= MAX_OUTSTANDING; i++) begin
        if (i_release && i_rel_tag == MEM_TAG'(i)) r_busy[i] <= 1'b0;
        if (i_alloc && w_free_tag == MEM_TAG'(i))  r_busy[i] <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/imem_responder.sv
// Memory-side responder: accepts loads/stores with tags, returns load lines
// after a fixed latency from a line-addressed behavioural array.
module imem_responder
  import sys_defs::*;
#(
  parameter int LATENCY         = 10,
  parameter int MAX_OUTSTANDING = 15,
  parameter int MEM_LINES       = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          pref2Imem_cmd,
  input  logic [SYS_XLEN-1:0] pref2Imem_addr,
  input  logic [63:0]         pref2Imem_data,
  output MEM_TAG              Imem2pref_response,
  output logic [63:0]         Imem2pref_data,
  output MEM_TAG              Imem2pref_tag
);
  localparam int IDX_W = $clog2(MEM_LINES);

  logic [63:0] r_mem [MEM_LINES];
  logic [63:0] r_buf [1:MAX_OUTSTANDING];
  logic [4:0]  r_cnt [1:MAX_OUTSTANDING];
  logic [MAX_OUTSTANDING:1] r_pend;
  MEM_TAG      r_ret_tag;
  logic [63:0] r_ret_data;

  MEM_TAG           w_free_tag;
  logic             w_full, w_accept, w_load, w_store;
  logic [IDX_W-1:0] w_idx;
  logic             w_fire;
  MEM_TAG           w_fire_tag;
  logic [63:0]      w_fire_data;
  logic             w_unused_addr;

  assign w_idx         = pref2Imem_addr[3 +: IDX_W];
  assign w_unused_addr = ^{pref2Imem_addr[SYS_XLEN-1:3+IDX_W], pref2Imem_addr[2:0]};

  assign w_accept = rst && !w_full &&
                    (pref2Imem_cmd == BUS_LOAD || pref2Imem_cmd == BUS_STORE);
  assign w_load   = w_accept && pref2Imem_cmd == BUS_LOAD;
  assign w_store  = w_accept && pref2Imem_cmd == BUS_STORE;
  assign Imem2pref_response = w_accept ? w_free_tag : '0;

  // Stores take a tag only for the handshake; it is never marked busy.
  // A tag is released while its return is on the output registers.
  mem_tag_alloc #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_alloc (
    .clk        (clk),
    .rst        (rst),
    .i_alloc    (w_load),
    .i_release  (r_ret_tag != '0),
    .i_rel_tag  (r_ret_tag),
    .o_free_tag (w_free_tag),
    .o_full     (w_full)
  );

  always_ff @(posedge clk) begin
    if (w_store) r_mem[w_idx] <= pref2Imem_data;
  end

  always_ff @(posedge clk) begin
    for (int i = 1; i <= MAX_OUTSTANDING; i++)
      if (w_load && w_free_tag == MEM_TAG'(i)) r_buf[i] <= r_mem[w_idx];
  end

  // Loads are accepted one per cycle, so at most one counter reaches 1 at once.
  always_comb begin
    w_fire      = 1'b0;
    w_fire_tag  = '0;
    w_fire_data = '0;
    for (int i = 1; i <= MAX_OUTSTANDING; i++)
      if (r_pend[i] && r_cnt[i] == 5'd1) begin
        w_fire      = 1'b1;
        w_fire_tag  = MEM_TAG'(i);
        w_fire_data = r_buf[i];
      end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pend <= '0;
      for (int i = 1; i <= MAX_OUTSTANDING; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 1; i <= MAX_OUTSTANDING; i++) begin
        if (w_load && w_free_tag == MEM_TAG'(i)) begin
          r_pend[i] <= 1'b1;
          r_cnt[i]  <= 5'(LATENCY - 1);
        end else if (r_pend[i]) begin
          r_cnt[i] <= r_cnt[i] - 5'd1;
          if (r_cnt[i] == 5'd1) r_pend[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ret_tag  <= '0;
      r_ret_data <= '0;
    end else begin
      r_ret_tag  <= w_fire ? w_fire_tag : '0;
      r_ret_data <= w_fire_data;
    end
  end

  assign Imem2pref_tag  = r_ret_tag;
  assign Imem2pref_data = r_ret_data;
endmodule

// File: tb/tb_imem_responder.sv
// Randomised and directed bench for imem_responder against a queue-based model.
module tb_imem_responder;
  localparam int LAT  = 16;
  localparam int MAXO = 15;
  localparam int ML   = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  cmd;
  logic [31:0] addr;
  logic [63:0] wdata;
  logic [3:0]  resp, rtag;
  logic [63:0] rdata;

  imem_responder #(.LATENCY(LAT), .MAX_OUTSTANDING(MAXO), .MEM_LINES(ML)) dut (
    .clk                (clk),
    .rst                (rst),
    .pref2Imem_cmd      (cmd),
    .pref2Imem_addr     (addr),
    .pref2Imem_data     (wdata),
    .Imem2pref_response (resp),
    .Imem2pref_data     (rdata),
    .Imem2pref_tag      (rtag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  tag;
    int          due;
    logic [63:0] data;
  } ent_t;

  ent_t        q[$];
  logic [63:0] mm [int];
  bit          m_busy [1:MAXO];
  int          cyc = 0;
  int          n_vec = 0, n_err = 0;
  logic [3:0]  e_resp, e_tag;
  logic [63:0] e_data;

  // Drive one cycle of inputs, compute expected outputs for this cycle,
  // then advance the model to the end of the cycle.
  task automatic apply(input logic r, input logic [1:0] c, input logic [31:0] a,
                       input logic [63:0] d);
    int idx;
    @(negedge clk);
    rst = r; cmd = c; addr = a; wdata = d;
    #1;
    e_tag = 0; e_data = 0;
    foreach (q[i]) if (q[i].due == cyc) begin e_tag = q[i].tag; e_data = q[i].data; end
    e_resp = 0;
    if (r && (c == 2'd1 || c == 2'd2))
      for (int t = MAXO; t >= 1; t--) if (!m_busy[t]) e_resp = 4'(t);
    idx = int'((a >> 3) % ML);
    if (e_resp != 0) begin
      if (c == 2'd2) mm[idx] = d;
      else begin
        m_busy[e_resp] = 1'b1;
        q.push_back('{e_resp, cyc + LAT, mm.exists(idx) ? mm[idx] : 64'h0});
      end
    end
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].due == cyc) begin m_busy[q[i].tag] = 1'b0; q.delete(i); end
    if (!r) begin
      q.delete();
      for (int t = 1; t <= MAXO; t++) m_busy[t] = 1'b0;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(1'b1, 2'd0, 32'h0, 64'h0);
  endtask

  task automatic test_reset;
    for (int k = 0; k < 5; k++) begin
      apply(k >= 2, 2'd0, 32'h0, 64'h0);
      n_vec++;
      if (resp !== 4'd0) begin n_err++; $display("FAIL reset_resp k=%0d got=%0d exp=0", k, resp); end
      if (k >= 1) begin
        n_vec++;
        if (rtag !== 4'd0 || rdata !== 64'h0) begin
          n_err++; $display("FAIL reset_out k=%0d tag=%0d data=%h exp=0/0", k, rtag, rdata);
        end
      end
    end
  endtask

  task automatic test_store_load;
    apply(1'b1, 2'd2, 32'h40, 64'hDEAD_BEEF_0000_0001);
    n_vec++;
    if (resp !== 4'd1) begin n_err++; $display("FAIL sl_store_resp got=%0d exp=1", resp); end
    apply(1'b1, 2'd1, 32'h40, 64'h0);
    n_vec++;
    if (resp !== 4'd1) begin n_err++; $display("FAIL sl_load_resp got=%0d exp=1", resp); end
    for (int k = 2; k <= LAT + 2; k++) begin
      apply(1'b1, 2'd0, 32'h0, 64'h0);
      n_vec++;
      if (k == LAT + 1) begin
        if (rtag !== 4'd1 || rdata !== 64'hDEAD_BEEF_0000_0001) begin
          n_err++; $display("FAIL sl_return k=%0d tag=%0d data=%h exp=1/deadbeef00000001", k, rtag, rdata);
        end
      end else if (rtag !== 4'd0 || rdata !== 64'h0) begin
        n_err++; $display("FAIL sl_quiet k=%0d tag=%0d data=%h exp=0/0", k, rtag, rdata);
      end
    end
  endtask

  task automatic test_pool_full;
    apply(1'b1, 2'd2, 32'h100, 64'h1234);
    for (int k = 0; k < MAXO; k++) begin
      apply(1'b1, 2'd1, 32'h100, 64'h0);
      n_vec++;
      if (resp !== 4'(k + 1)) begin n_err++; $display("FAIL full_alloc k=%0d got=%0d exp=%0d", k, resp, k + 1); end
    end
    for (int k = MAXO; k <= LAT + 1; k++) begin
      apply(1'b1, 2'd1, 32'h100, 64'h0);
      n_vec++;
      if (resp !== ((k == LAT + 1) ? 4'd1 : 4'd0)) begin
        n_err++; $display("FAIL full_retry k=%0d got=%0d exp=%0d", k, resp, (k == LAT + 1) ? 1 : 0);
      end
      n_vec++;
      if (rtag !== e_tag || rdata !== e_data) begin
        n_err++; $display("FAIL full_ret k=%0d tag=%0d data=%h exp=%0d/%h", k, rtag, rdata, e_tag, e_data);
      end
    end
    idle(LAT + 2);
  endtask

  task automatic test_snapshot;
    apply(1'b1, 2'd2, 32'h80, 64'h0000_0000_0BAD_F00D);
    apply(1'b1, 2'd1, 32'h80, 64'h0);
    apply(1'b1, 2'd2, 32'h80, 64'h5555_AAAA_5555_AAAA);
    for (int k = 2; k <= LAT; k++) apply(1'b1, 2'd0, 32'h0, 64'h0);
    n_vec++;
    if (rtag !== 4'd1 || rdata !== 64'h0000_0000_0BAD_F00D) begin
      n_err++; $display("FAIL snapshot tag=%0d data=%h exp=1/000000000badf00d", rtag, rdata);
    end
    idle(2);
  endtask

  task automatic test_wrap;
    apply(1'b1, 2'd2, ML * 8 + 32'h8, 64'hCAFE_0000_0000_0008);
    apply(1'b1, 2'd3, 32'h8, 64'hFFFF_FFFF_FFFF_FFFF);
    n_vec++;
    if (resp !== 4'd0) begin n_err++; $display("FAIL cmd3_resp got=%0d exp=0", resp); end
    apply(1'b1, 2'd1, 32'h8, 64'h0);
    for (int k = 1; k <= LAT; k++) apply(1'b1, 2'd0, 32'h0, 64'h0);
    n_vec++;
    if (rtag !== 4'd1 || rdata !== 64'hCAFE_0000_0000_0008) begin
      n_err++; $display("FAIL wrap_load tag=%0d data=%h exp=1/cafe000000000008", rtag, rdata);
    end
    idle(2);
  endtask

  task automatic test_reset_midflight;
    for (int k = 0; k < 3; k++) apply(1'b1, 2'd1, 32'h40, 64'h0);
    apply(1'b0, 2'd0, 32'h0, 64'h0);
    for (int k = 0; k < LAT + 3; k++) begin
      apply(1'b1, 2'd0, 32'h0, 64'h0);
      n_vec++;
      if (rtag !== 4'd0 || rdata !== 64'h0) begin
        n_err++; $display("FAIL midrst_quiet k=%0d tag=%0d data=%h exp=0/0", k, rtag, rdata);
      end
    end
    apply(1'b1, 2'd1, 32'h40, 64'h0);
    n_vec++;
    if (resp !== 4'd1) begin n_err++; $display("FAIL midrst_resp got=%0d exp=1", resp); end
    idle(LAT + 1);
  endtask

  task automatic test_random;
    logic [1:0]  c;
    logic [31:0] a;
    for (int k = 0; k < 8; k++) apply(1'b1, 2'd2, 32'((k + 32) * 8), {$urandom, $urandom});
    for (int k = 0; k < 400; k++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: c = 2'd1;
        6, 7:             c = 2'd2;
        8:                c = 2'd3;
        default:          c = 2'd0;
      endcase
      a = 32'($urandom_range(0, 3) * ML * 8 + ($urandom_range(0, 7) + 32) * 8 + $urandom_range(0, 7));
      apply(1'b1, c, a, {$urandom, $urandom});
      n_vec++;
      if (resp !== e_resp) begin n_err++; $display("FAIL rand_resp k=%0d got=%0d exp=%0d", k, resp, e_resp); end
      n_vec++;
      if (rtag !== e_tag || rdata !== e_data) begin
        n_err++; $display("FAIL rand_ret k=%0d tag=%0d data=%h exp=%0d/%h", k, rtag, rdata, e_tag, e_data);
      end
    end
    for (int k = 0; k < LAT + 2; k++) begin
      apply(1'b1, 2'd0, 32'h0, 64'h0);
      n_vec++;
      if (rtag !== e_tag || rdata !== e_data) begin
        n_err++; $display("FAIL drain_ret k=%0d tag=%0d data=%h exp=%0d/%h", k, rtag, rdata, e_tag, e_data);
      end
    end
  endtask

  initial begin
    rst = 1'b0; cmd = 2'd0; addr = '0; wdata = '0;
    for (int t = 1; t <= MAXO; t++) m_busy[t] = 1'b0;
    test_reset;
    test_store_load;
    test_pool_full;
    test_snapshot;
    test_wrap;
    test_reset_midflight;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
